hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core; generates all stall/flush controls for IF/ID/EX/MEM.
- Resolves load-use and branch-in-decode load hazards that the decode-stage branch forwarding path cannot cover.
- Sequences the fixed-latency multi-cycle MDU occupying EX.
- Counts stall and flush cycles for performance monitoring.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_match.sv | 14 +
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the MDU datapath.
package hazard_pkg;

    typedef enum logic {
        HZ_RUN,
        HZ_MDU
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // The MDU datapath imports this too, so both sides agree on the latency.
    localparam int MDU_LAT_DEFAULT = 4;

endpackage

// File: rtl/hazard_match.sv
// Register-compare of one source operand against one producer stage; x0 never matches.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       used,
    input  logic [4:0] rd,
    input  logic       wren,
    output logic       hit
);

    assign hit = used && (rs != REG_X0) && (rs == rd) && wren;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for IF/ID/EX/MEM: load-use, branch-on-load and MDU occupancy,
// plus free-running stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT,
    parameter int CNT_W   = $clog2(MDU_LAT),
    parameter int PERF_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [4:0]        i_rs1_addr_D,
    input  logic [4:0]        i_rs2_addr_D,
    input  logic              i_rs1_used_D,
    input  logic              i_rs2_used_D,
    input  logic              i_is_br_D,
    input  logic              i_br_taken_D,
    input  logic [4:0]        i_rd_addr_E,
    input  logic              i_rd_wren_E,
    input  logic              i_is_load_E,
    input  logic              i_mdu_start_E,
    input  logic [4:0]        i_rd_addr_M,
    input  logic              i_rd_wren_M,
    input  logic              i_is_load_M,
    output logic              o_stall_F,
    output logic              o_stall_D,
    output logic              o_stall_E,
    output logic              o_flush_D,
    output logic              o_flush_E,
    output logic              o_flush_M,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MDU_LAT - 2);

    hz_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              m1_e, m2_e, m1_m, m2_m;
    logic              lu, bl_m, hz, mdu_busy;
    logic              stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

    hazard_match u_m1_e (.rs(i_rs1_addr_D), .used(i_rs1_used_D), .rd(i_rd_addr_E), .wren(i_rd_wren_E), .hit(m1_e));
    hazard_match u_m2_e (.rs(i_rs2_addr_D), .used(i_rs2_used_D), .rd(i_rd_addr_E), .wren(i_rd_wren_E), .hit(m2_e));
    hazard_match u_m1_m (.rs(i_rs1_addr_D), .used(i_rs1_used_D), .rd(i_rd_addr_M), .wren(i_rd_wren_M), .hit(m1_m));
    hazard_match u_m2_m (.rs(i_rs2_addr_D), .used(i_rs2_used_D), .rd(i_rd_addr_M), .wren(i_rd_wren_M), .hit(m2_m));

    // Branches resolve in ID, so a load still in MEM is too late for them to forward from.
    assign lu   = i_is_load_E & (m1_e | m2_e);
    assign bl_m = i_is_br_D & i_is_load_M & (m1_m | m2_m);
    assign hz   = lu | bl_m;

    assign mdu_busy = ((state == HZ_RUN) && i_mdu_start_E) || ((state == HZ_MDU) && (cnt != '0));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        if (mdu_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            if (state == HZ_RUN) begin
                state_nxt = HZ_MDU;
                cnt_nxt   = CNT_RELOAD;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end else begin
            // Last MDU cycle behaves like RUN; the op leaves EX at this edge.
            state_nxt = HZ_RUN;
            if (hz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                flush_d = i_br_taken_D;
            end
        end
    end

    assign o_stall_F = stall_f & i_rst_n;
    assign o_stall_D = stall_d & i_rst_n;
    assign o_stall_E = stall_e & i_rst_n;
    assign o_flush_D = flush_d & i_rst_n;
    assign o_flush_E = flush_e & i_rst_n;
    assign o_flush_M = flush_m & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= HZ_RUN;
            cnt         <= '0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (o_stall_D) o_stall_cnt <= o_stall_cnt + 1'b1;
            if (o_flush_D) o_flush_cnt <= o_flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance runs with MDU_LAT=2.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rd_e, rd_m;
    logic        rs1_used, rs2_used, is_br, br_taken;
    logic        wren_e, load_e, mdu_start, wren_m, load_m;

    logic        s_f, s_d, s_e, f_d, f_e, f_m;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s2_f, s2_d, s2_e, f2_d, f2_e, f2_m;
    logic [31:0] stall_cnt2, flush_cnt2;

    logic [5:0]  ctrl, ctrl2;
    int          checks = 0;
    int          errors = 0;

    // Packed {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110010;
    localparam logic [5:0] C_REDIR = 6'b000100;
    localparam logic [5:0] C_MDU   = 6'b111001;

    assign ctrl  = {s_f, s_d, s_e, f_d, f_e, f_m};
    assign ctrl2 = {s2_f, s2_d, s2_e, f2_d, f2_e, f2_m};

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_addr_D(rs1_d), .i_rs2_addr_D(rs2_d),
        .i_rs1_used_D(rs1_used), .i_rs2_used_D(rs2_used),
        .i_is_br_D(is_br), .i_br_taken_D(br_taken),
        .i_rd_addr_E(rd_e), .i_rd_wren_E(wren_e), .i_is_load_E(load_e), .i_mdu_start_E(mdu_start),
        .i_rd_addr_M(rd_m), .i_rd_wren_M(wren_m), .i_is_load_M(load_m),
        .o_stall_F(s_f), .o_stall_D(s_d), .o_stall_E(s_e),
        .o_flush_D(f_d), .o_flush_E(f_e), .o_flush_M(f_m),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MDU_LAT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_addr_D(rs1_d), .i_rs2_addr_D(rs2_d),
        .i_rs1_used_D(rs1_used), .i_rs2_used_D(rs2_used),
        .i_is_br_D(is_br), .i_br_taken_D(br_taken),
        .i_rd_addr_E(rd_e), .i_rd_wren_E(wren_e), .i_is_load_E(load_e), .i_mdu_start_E(mdu_start),
        .i_rd_addr_M(rd_m), .i_rd_wren_M(wren_m), .i_is_load_M(load_m),
        .o_stall_F(s2_f), .o_stall_D(s2_d), .o_stall_E(s2_e),
        .o_flush_D(f2_d), .o_flush_E(f2_e), .o_flush_M(f2_m),
        .o_stall_cnt(stall_cnt2), .o_flush_cnt(flush_cnt2)
    );

    task automatic idle_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        is_br = 1'b0; br_taken = 1'b0;
        rd_e = 5'd0; wren_e = 1'b0; load_e = 1'b0; mdu_start = 1'b0;
        rd_m = 5'd0; wren_m = 1'b0; load_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        // Hazard and redirect present but reset must mask everything.
        rd_e = 5'd5; wren_e = 1'b1; load_e = 1'b1;
        rs1_d = 5'd5; rs1_used = 1'b1; br_taken = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE); end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        mdu_start = 1'b1;
        #1;
        checks++;
        if (ctrl2 !== C_NONE) begin errors++; $display("[TB] FAIL reset_ctrl2: got %b expected %b", ctrl2, C_NONE); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        rd_e = 5'd5; wren_e = 1'b1; load_e = 1'b1;
        rs1_d = 5'd5; rs2_d = 5'd1; rs1_used = 1'b1; rs2_used = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("[TB] FAIL lu_ctrl: got %b expected %b", ctrl, C_LU); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL lu_cnt_before: got %0d expected 0", stall_cnt); end
        @(negedge clk);
        rd_e = 5'd0; wren_e = 1'b0; load_e = 1'b0;
        rd_m = 5'd5; wren_m = 1'b1; load_m = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL lu_release: got %b expected %b", ctrl, C_NONE); end
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL lu_cnt_after: got %0d expected 1", stall_cnt); end
        // rs2-only dependency must also be caught
        @(negedge clk);
        rd_m = 5'd0; wren_m = 1'b0; load_m = 1'b0;
        rd_e = 5'd9; wren_e = 1'b1; load_e = 1'b1;
        rs1_d = 5'd3; rs2_d = 5'd9;
        #1;
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("[TB] FAIL lu_rs2: got %b expected %b", ctrl, C_LU); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        @(negedge clk);
        rd_e = 5'd0; wren_e = 1'b1; load_e = 1'b1;
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_used = 1'b1; rs2_used = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL x0_load: got %b expected %b", ctrl, C_NONE); end
        @(negedge clk);
        rd_e = 5'd7; rs1_d = 5'd7; rs2_d = 5'd7; rs1_used = 1'b0; rs2_used = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL unused_rs: got %b expected %b", ctrl, C_NONE); end
        // Branch on an ALU result in EX is forwarded, no stall; redirect goes through.
        @(negedge clk);
        load_e = 1'b0; rs1_used = 1'b1; is_br = 1'b1; br_taken = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_REDIR) begin errors++; $display("[TB] FAIL br_alu_fwd: got %b expected %b", ctrl, C_REDIR); end
        // Non-branch reading a load in MEM is forwarded, no stall.
        @(negedge clk);
        is_br = 1'b0; br_taken = 1'b0; wren_e = 1'b0;
        rd_m = 5'd7; wren_m = 1'b1; load_m = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL alu_load_m: got %b expected %b", ctrl, C_NONE); end
    endtask

    task automatic test_branch_load();
        do_reset();
        @(negedge clk);
        rd_e = 5'd5; wren_e = 1'b1; load_e = 1'b1;
        rs1_d = 5'd5; rs2_d = 5'd0; rs1_used = 1'b1; rs2_used = 1'b1;
        is_br = 1'b1; br_taken = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("[TB] FAIL bl_lu: got %b expected %b", ctrl, C_LU); end
        @(negedge clk);
        rd_e = 5'd0; wren_e = 1'b0; load_e = 1'b0;
        rd_m = 5'd5; wren_m = 1'b1; load_m = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("[TB] FAIL bl_blm: got %b expected %b", ctrl, C_LU); end
        @(negedge clk);
        rd_m = 5'd0; wren_m = 1'b0; load_m = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_REDIR) begin errors++; $display("[TB] FAIL bl_redirect: got %b expected %b", ctrl, C_REDIR); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (flush_cnt !== 32'd1) begin errors++; $display("[TB] FAIL bl_flush_cnt: got %0d expected 1", flush_cnt); end
        checks++;
        if (stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL bl_stall_cnt: got %0d expected 2", stall_cnt); end
        // Branch on rs2 against a load in MEM
        @(negedge clk);
        is_br = 1'b1; rs2_d = 5'd12; rs2_used = 1'b1;
        rd_m = 5'd12; wren_m = 1'b1; load_m = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("[TB] FAIL bl_rs2: got %b expected %b", ctrl, C_LU); end
    endtask

    task automatic test_mdu();
        logic [5:0] exp_ctrl;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mdu_start = 1'b1;
            br_taken  = (i == 1 || i == 3);
            #1;
            exp_ctrl = (i < 3) ? C_MDU : C_REDIR;
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++; $display("[TB] FAIL mdu_cycle%0d: got %b expected %b", i, ctrl, exp_ctrl);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL mdu_done: got %b expected %b", ctrl, C_NONE); end
        checks++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            errors++; $display("[TB] FAIL mdu_cnt: got %0d/%0d expected 3/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mdu_lat2();
        logic [5:0] exp_ctrl;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mdu_start = 1'b1;
            #1;
            exp_ctrl = (i == 0) ? C_MDU : C_NONE;
            checks++;
            if (ctrl2 !== exp_ctrl) begin
                errors++; $display("[TB] FAIL mdu2_cycle%0d: got %b expected %b", i, ctrl2, exp_ctrl);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt2 !== 32'd1) begin errors++; $display("[TB] FAIL mdu2_cnt: got %0d expected 1", stall_cnt2); end
    endtask

    task automatic test_mdu_reset();
        logic [5:0] exp_ctrl;
        do_reset();
        @(negedge clk);
        mdu_start = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_MDU) begin errors++; $display("[TB] FAIL mrst_first: got %b expected %b", ctrl, C_MDU); end
        @(negedge clk);
        #1;
        checks++;
        if (ctrl !== C_MDU || stall_cnt !== 32'd1) begin
            errors++; $display("[TB] FAIL mrst_second: got %b/%0d expected %b/1", ctrl, stall_cnt, C_MDU);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin errors++; $display("[TB] FAIL mrst_ctrl: got %b expected %b", ctrl, C_NONE); end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL mrst_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            exp_ctrl = (i < 3) ? C_MDU : C_NONE;
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++; $display("[TB] FAIL mrst_restart%0d: got %b expected %b", i, ctrl, exp_ctrl);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 32'd3) begin errors++; $display("[TB] FAIL mrst_stall_cnt: got %0d expected 3", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_load();
        test_mdu();
        test_mdu_lat2();
        test_mdu_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
